ir_nec_tx: RTL and testbench

- NEC-protocol infrared transmitter. The transmit-side counterpart of the IR receive path that decodes IRDA_RXD into IR_button.
- Accepts an 8-bit address and 8-bit command, or a repeat request, over a valid/ready handshake.
- Emits the NEC pulse-distance frame on an IR LED driver output, with optional 38 kHz carrier modulation.
- Used for board-to-board control and as a loopback stimulus source for the IR receiver.

---
 rtl/ir_nec_tx.sv | 183 ++++++++++++++++++
 tb/tb_ir_nec_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: takes an address/command (or a repeat request) over a
// valid/ready handshake and plays the pulse-distance frame out on ir_tx.
module ir_nec_tx #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658,
  parameter bit MODULATE     = 1'b1,
  parameter int GAP_UNITS    = 72
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_repeat,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_cmd,
  output logic       ir_tx,
  output logic       ir_envelope,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_REP_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_GAP
  } state_t;

  localparam int MAX_UNITS = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int UW        = $clog2(UNIT_CYCLES);
  localparam int PW        = $clog2(MAX_UNITS);
  localparam int CW        = $clog2(2 * CARRIER_HALF);

  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] CAR_LAST  = CW'(2 * CARRIER_HALF - 1);
  localparam logic [CW-1:0] CAR_HALF  = CW'(CARRIER_HALF);

  state_t          state_q, state_d;
  logic [UW-1:0]   unit_q, unit_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [31:0]     shift_q, shift_d;
  logic [4:0]      bit_q, bit_d;
  logic            rep_q, rep_d;
  logic [CW-1:0]   car_q, car_d;
  logic            env_q, env_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;

  logic [PW-1:0]   last_phase;
  logic            unit_end;
  logic            state_end;
  logic            transfer;
  logic            mark_entry;
  logic            car_hi;

  // Durations are stored as (units - 1) so a 16-unit state fits in a 4-bit counter.
  always_comb begin
    last_phase = '0;
    case (state_q)
      S_LEAD_MARK:  last_phase = PW'(15);
      S_LEAD_SPACE: last_phase = PW'(7);
      S_REP_SPACE:  last_phase = PW'(3);
      S_BIT_SPACE:  last_phase = shift_q[0] ? PW'(2) : PW'(0);
      S_GAP:        last_phase = PW'(GAP_UNITS - 1);
      default:      last_phase = '0;
    endcase
  end

  assign unit_end  = (unit_q == UNIT_LAST);
  assign state_end = unit_end && (phase_q == last_phase);
  assign transfer  = tx_valid && ready_q;

  // NOTE: every variable driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    phase_d = phase_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    done_d  = 1'b0;

    if (state_q == S_IDLE) begin
      unit_d  = '0;
      phase_d = '0;
      if (transfer) begin
        state_d = S_LEAD_MARK;
        shift_d = {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
        rep_d   = tx_repeat;
        bit_d   = '0;
      end
    end else if (state_end) begin
      unit_d  = '0;
      phase_d = '0;
      case (state_q)
        S_LEAD_MARK:  state_d = rep_q ? S_REP_SPACE : S_LEAD_SPACE;
        S_LEAD_SPACE: begin
          state_d = S_BIT_MARK;
          bit_d   = '0;
        end
        S_REP_SPACE:  state_d = S_STOP_MARK;
        S_BIT_MARK:   state_d = S_BIT_SPACE;
        S_BIT_SPACE: begin
          shift_d = {1'b0, shift_q[31:1]};
          bit_d   = bit_q + 5'd1;
          state_d = (bit_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
        end
        S_STOP_MARK:  state_d = S_GAP;
        S_GAP: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        default:      state_d = S_IDLE;
      endcase
    end else if (unit_end) begin
      unit_d  = '0;
      phase_d = phase_q + PW'(1);
    end else begin
      unit_d = unit_q + UW'(1);
    end
  end

  // Outputs are computed from the next state so they change on the same edge as it.
  always_comb begin
    env_d      = (state_d == S_LEAD_MARK) || (state_d == S_BIT_MARK) ||
                 (state_d == S_STOP_MARK);
    mark_entry = env_d && (state_d != state_q);
    car_d      = '0;
    if (env_d && !mark_entry) begin
      car_d = (car_q == CAR_LAST) ? '0 : car_q + CW'(1);
    end
    car_hi  = env_d && (car_d < CAR_HALF);
    tx_d    = MODULATE ? car_hi : env_d;
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      unit_q  <= '0;
      phase_q <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      rep_q   <= 1'b0;
      car_q   <= '0;
      env_q   <= 1'b0;
      tx_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      phase_q <= phase_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      car_q   <= car_d;
      env_q   <= env_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign tx_ready    = ready_q;
  assign ir_tx       = tx_q;
  assign ir_envelope = env_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx: a modulated and an unmodulated instance share the stimulus;
// a monitor decodes each frame and compares it against a queued expected frame.
module tb_ir_nec_tx;

  localparam int UNIT = 4;
  localparam int HALF = 1;
  localparam int GAP  = 2;

  logic       clk_50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_repeat = 1'b0;
  logic [7:0] tx_addr = 8'h00;
  logic [7:0] tx_cmd = 8'h00;
  logic       m_ready, m_tx, m_env, m_busy, m_done;
  logic       r_ready, r_tx, r_env, r_busy, r_done;

  always #5 clk_50 = ~clk_50;

  ir_nec_tx #(.UNIT_CYCLES(UNIT), .CARRIER_HALF(HALF), .MODULATE(1'b1), .GAP_UNITS(GAP)) u_mod (
    .clk_50(clk_50), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(m_ready),
    .tx_repeat(tx_repeat), .tx_addr(tx_addr), .tx_cmd(tx_cmd), .ir_tx(m_tx),
    .ir_envelope(m_env), .busy(m_busy), .done(m_done)
  );

  ir_nec_tx #(.UNIT_CYCLES(UNIT), .CARRIER_HALF(HALF), .MODULATE(1'b0), .GAP_UNITS(GAP)) u_raw (
    .clk_50(clk_50), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(r_ready),
    .tx_repeat(tx_repeat), .tx_addr(tx_addr), .tx_cmd(tx_cmd), .ir_tx(r_tx),
    .ir_envelope(r_env), .busy(r_busy), .done(r_done)
  );

  typedef struct {
    bit          rep;
    logic [7:0]  addr;
    logic [7:0]  cmd;
    bit          hold;
    logic [31:0] word;
    int          nbits;
    int          busy_cyc;
    int          mark_cyc;
    int          pulses;
  } vec_t;

  vec_t vecs[5];
  vec_t exp_q[$];
  vec_t cur;
  bit   exp_env[$];
  bit   exp_car[$];

  int checks = 0;
  int errors = 0;
  int frames_done = 0;
  int done_pulses = 0;
  bit aborting = 1'b0;
  bit last_hold = 1'b0;

  bit          in_frame = 1'b0;
  int          idx, env_err, tx_err, raw_err, rdy_err, mark_cyc, pulses, run_len, nbits;
  bit          prev_env;
  logic [31:0] word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_seg(input bit lvl, input int units);
    for (int c = 0; c < units * UNIT; c++) begin
      exp_env.push_back(lvl);
      exp_car.push_back(lvl && ((c % (2 * HALF)) < HALF));
    end
  endtask

  // On-air order: addr, ~addr, cmd, ~cmd, each LSB first.
  task automatic build_wave(input vec_t v);
    logic [7:0] bytes[4];
    bytes[0] = v.addr;
    bytes[1] = ~v.addr;
    bytes[2] = v.cmd;
    bytes[3] = ~v.cmd;
    exp_env.delete();
    exp_car.delete();
    add_seg(1'b1, 16);
    if (v.rep) begin
      add_seg(1'b0, 4);
    end else begin
      add_seg(1'b0, 8);
      for (int i = 0; i < 32; i++) begin
        add_seg(1'b1, 1);
        add_seg(1'b0, bytes[i / 8][i % 8] ? 3 : 1);
      end
    end
    add_seg(1'b1, 1);
    add_seg(1'b0, GAP);
  endtask

  initial begin
    forever begin
      @(negedge clk_50);
      if (m_done === 1'b1) done_pulses++;
      if (in_frame && m_busy !== 1'b1) begin
        in_frame = 1'b0;
        if (aborting) begin
          aborting = 1'b0;
        end else begin
          frames_done++;
          check("busy_len", idx, cur.busy_cyc);
          check("env_wave_errs", env_err, 0);
          check("mod_tx_errs", tx_err, 0);
          check("raw_tx_errs", raw_err, 0);
          check("handshake_while_busy", rdy_err, 0);
          check("done_at_end", m_done, 1);
          check("mark_cycles", mark_cyc, cur.mark_cyc);
          check("mark_pulses", pulses, cur.pulses);
          check("bit_count", nbits, cur.nbits);
          if (!cur.rep) check("word", word, cur.word);
        end
      end
      if (!in_frame && m_busy === 1'b1) begin
        check("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        build_wave(cur);
        in_frame = 1'b1;
        idx = 0; env_err = 0; tx_err = 0; raw_err = 0; rdy_err = 0;
        mark_cyc = 0; pulses = 0; run_len = 0; nbits = 0; word = '0;
        prev_env = 1'b0;
      end
      if (in_frame) begin
        if (idx < exp_env.size()) begin
          if (m_env !== exp_env[idx]) env_err++;
          if (m_tx !== exp_car[idx]) tx_err++;
          if (r_env !== exp_env[idx] || r_tx !== exp_env[idx]) raw_err++;
        end else begin
          env_err++;
        end
        if (m_ready !== 1'b0 || r_ready !== 1'b0 || r_busy !== 1'b1 ||
            m_done !== 1'b0 || r_done !== 1'b0) rdy_err++;
        if (m_env === 1'b1) mark_cyc++;
        if (m_env === 1'b1 && !prev_env) begin
          pulses++;
          if ((run_len == UNIT || run_len == 3 * UNIT) && nbits < 32) begin
            word[nbits] = (run_len == 3 * UNIT);
            nbits++;
          end
        end
        if (m_env === prev_env) run_len++;
        else run_len = 1;
        prev_env = (m_env === 1'b1);
        idx++;
      end
    end
  end

  task automatic send(input vec_t v);
    int n;
    tx_addr   = v.addr;
    tx_cmd    = v.cmd;
    tx_repeat = v.rep;
    tx_valid  = 1'b1;
    n = 0;
    while (m_ready !== 1'b1 && n < 2000) begin
      @(negedge clk_50);
      n++;
    end
    if (m_ready !== 1'b1) check("ready_before_timeout", m_ready, 1);
    if (last_hold) check("b2b_abut_at_done", m_done, 1);
    exp_q.push_back(v);
    @(negedge clk_50);
    if (!v.hold) tx_valid = 1'b0;
    last_hold = v.hold;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy !== 1'b0 && n < 3000) begin
      @(negedge clk_50);
      n++;
    end
    if (m_busy !== 1'b0) check("idle_before_timeout", m_busy, 0);
    repeat (2) @(negedge clk_50);
  endtask

  initial begin
    int   idle_bad;
    int   dp0;
    vec_t v;

    vecs[0] = '{1'b0, 8'h00, 8'h45, 1'b0, 32'hBA45FF00, 32, 492, 196, 34};
    vecs[1] = '{1'b1, 8'h12, 8'h34, 1'b0, 32'h00000000, 0, 92, 68, 2};
    vecs[2] = '{1'b0, 8'hA5, 8'h3C, 1'b1, 32'hC33C5AA5, 32, 492, 196, 34};
    vecs[3] = '{1'b0, 8'hFF, 8'h00, 1'b1, 32'hFF0000FF, 32, 492, 196, 34};
    vecs[4] = '{1'b0, 8'h12, 8'h34, 1'b0, 32'hCB34ED12, 32, 492, 196, 34};

    repeat (3) @(negedge clk_50);
    check("rst_ir_tx", m_tx, 0);
    check("rst_envelope", m_env, 0);
    check("rst_ready", m_ready, 1);
    check("rst_busy", m_busy, 0);
    rst_n = 1'b1;

    idle_bad = 0;
    repeat (20) begin
      @(negedge clk_50);
      if (m_tx !== 1'b0 || m_env !== 1'b0 || m_ready !== 1'b1 || m_busy !== 1'b0 ||
          m_done !== 1'b0 || r_tx !== 1'b0) idle_bad++;
    end
    check("idle_outputs", idle_bad, 0);

    for (int i = 0; i < 5; i++) send(vecs[i]);
    wait_idle();

    // A request arriving mid-frame must be dropped, not queued.
    v = vecs[0];
    v.addr = 8'h5A;
    v.cmd = 8'hC3;
    v.word = 32'h3CC3A55A;
    send(v);
    repeat (100) @(negedge clk_50);
    tx_addr = 8'hEE;
    tx_cmd = 8'h77;
    tx_valid = 1'b1;
    @(negedge clk_50);
    tx_valid = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk_50);
    check("ignored_no_frame", m_busy, 0);
    check("queue_empty", exp_q.size(), 0);

    // Reset during the space of bit 10 (cycle 200 of the frame).
    send(vecs[0]);
    repeat (200) @(negedge clk_50);
    #1;
    check("pre_reset_bits_seen", nbits, 10);
    check("pre_reset_in_space", m_env, 0);
    dp0 = done_pulses;
    aborting = 1'b1;
    rst_n = 1'b0;
    #1;
    check("abort_ir_tx", m_tx, 0);
    check("abort_envelope", m_env, 0);
    check("abort_busy", m_busy, 0);
    check("abort_ready", m_ready, 1);
    check("abort_raw_tx", r_tx, 0);
    repeat (3) @(negedge clk_50);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50);
    check("abort_no_done", done_pulses, dp0);
    check("abort_idle_busy", m_busy, 0);
    send(vecs[0]);
    wait_idle();

    check("frames_completed", frames_done, 7);
    check("done_pulse_count", done_pulses, 7);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
